// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// No logic of its own; imported by the unit, its divider and the interface users.
// Operation encodings follow the funct3 field of the M-extension instructions.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } muldiv_state_e;

    localparam int          MULDIV_ITER = 32;
    localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_QUOT    = 32'h8000_0000;

    // rs1 is treated as signed by MUL, MULH, MULHSU, DIV and REM
    function automatic logic op_a_signed(muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is treated as signed by MUL, MULH, DIV and REM
    function automatic logic op_b_signed(muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage <-> multiply/divide unit signal bundle.
// master = pipeline side (drives operands, start, flush); slave = the unit.
// stall is the only backpressure: the pipeline holds the instruction in EX while it is high.
interface ex_muldiv_unit_if;
    logic        flush;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    modport master (
        output flush, start, funct3, op_a, op_b, rd_in,
        input  stall, done, result, rd_out
    );

    modport slave (
        input  flush, start, funct3, op_a, op_b, rd_in,
        output stall, done, result, rd_out
    );
endinterface

// File: rtl/div_core_iter.sv
// Restoring divider datapath on unsigned magnitudes, one quotient bit per enabled cycle.
// Latency: W enabled cycles after load; quo_nxt/rem_nxt expose the value the next step will store.
// No backpressure: the controlling FSM decides when to load and step.
module div_core_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quo_nxt,
    output logic [W-1:0] rem_nxt
);

    logic [W-1:0] quo_q;
    logic [W-1:0] rem_q;
    logic [W-1:0] dvsr_q;
    logic [W:0]   trial;

    // Shift the next dividend bit into the partial remainder and try subtracting the divisor
    assign trial = {rem_q, quo_q[W-1]} - {1'b0, dvsr_q};

    // Keep the difference when it did not borrow, otherwise restore the shifted remainder
    always_comb begin
        rem_nxt = {rem_q[W-2:0], quo_q[W-1]};
        quo_nxt = {quo_q[W-2:0], 1'b0};
        if (!trial[W]) begin
            rem_nxt = trial[W-1:0];
            quo_nxt = {quo_q[W-2:0], 1'b1};
        end
    end

    // Load operands on accept, then advance one step per enabled cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
        end else if (load) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dvsr_q <= divisor;
        end else if (en) begin
            quo_q  <= quo_nxt;
            rem_q  <= rem_nxt;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit in EX; MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
// Latency: 33 stall cycles then done (iterative mul/div), 1 stall cycle for fast mul and div-by-zero/overflow.
// Backpressure: stall freezes IF/ID/EX until the DONE cycle; flush aborts and drops stall combinationally.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    ex_muldiv_unit_if.slave   bus
);

    muldiv_state_e   state_q;
    muldiv_op_e      op_in;
    muldiv_op_e      op_q;
    logic [4:0]      cnt_q;
    logic [4:0]      rd_q;
    logic [4:0]      rd_out_q;
    logic            neg_q;
    logic [XLEN-1:0] result_q;

    logic            accept;
    logic            a_neg;
    logic            b_neg;
    logic            is_div;
    logic            is_rem_q;
    logic            div0;
    logic            ovf;
    logic            neg_in;
    logic            last_iter;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] quo_nxt;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] div_raw;
    logic [XLEN-1:0] div_res;

    assign op_in     = muldiv_op_e'(bus.funct3);
    assign accept    = (state_q == ST_IDLE) && bus.start && !bus.flush;
    assign a_neg     = op_a_signed(op_in) && bus.op_a[XLEN-1];
    assign b_neg     = op_b_signed(op_in) && bus.op_b[XLEN-1];
    assign a_mag     = a_neg ? -bus.op_a : bus.op_a;
    assign b_mag     = b_neg ? -bus.op_b : bus.op_b;
    assign is_div    = op_in[2];
    assign div0      = (bus.op_b == '0);
    assign ovf       = is_div && op_a_signed(op_in) && (bus.op_a == OVF_QUOT) && (bus.op_b == DIV0_QUOT);
    assign last_iter = (cnt_q == 5'(MULDIV_ITER - 1));

    // Remainders follow the dividend sign; products and quotients negate when the signs differ
    assign neg_in      = (is_div && op_in[1]) ? a_neg : (a_neg ^ b_neg);
    assign special_res = op_in[1] ? (div0 ? bus.op_a : '0) : (div0 ? DIV0_QUOT : OVF_QUOT);

    assign is_rem_q = (op_q == OP_REM) || (op_q == OP_REMU);
    assign div_raw  = is_rem_q ? rem_nxt : quo_nxt;
    assign div_res  = neg_q ? -div_raw : div_raw;

    div_core_iter #(.W(XLEN)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && is_div && !div0 && !ovf),
        .en       ((state_q == ST_DIV) && !bus.flush),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fa;
    logic signed [XLEN:0]     fb;
    logic signed [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]          fast_res;

    // 33-bit operands carry the per-op sign extension so one signed product covers all four ops
    assign fa        = {op_a_signed(op_in) & bus.op_a[XLEN-1], bus.op_a};
    assign fb        = {op_b_signed(op_in) & bus.op_b[XLEN-1], bus.op_b};
    assign fast_prod = fa * fb;
    assign fast_res  = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
    logic [XLEN-1:0]   a_mag_q;
    logic [2*XLEN-1:0] prod_q;
    logic [2*XLEN-1:0] prod_nxt;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_res;

    // Multiplier sits in the low half; each step adds the multiplicand to the high half and shifts right
    assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
    assign prod_nxt = {mul_sum, prod_q[XLEN-1:1]};
    assign prod_fix = neg_q ? -prod_nxt : prod_nxt;
    assign mul_res  = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`endif

    // Control FSM and registered result/rd; flush returns to IDLE without touching the outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
`ifndef MULDIV_FAST_MUL_EN
            a_mag_q  <= '0;
            prod_q   <= '0;
`endif
        end else if (bus.flush) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q  <= op_in;
                        rd_q  <= bus.rd_in;
                        neg_q <= neg_in;
                        cnt_q <= '0;
                        if (!is_div) begin
`ifdef MULDIV_FAST_MUL_EN
                            result_q <= fast_res;
                            rd_out_q <= bus.rd_in;
                            state_q  <= ST_DONE;
`else
                            a_mag_q  <= a_mag;
                            prod_q   <= {{XLEN{1'b0}}, b_mag};
                            state_q  <= ST_MUL;
`endif
                        end else if (div0 || ovf) begin
                            result_q <= special_res;
                            rd_out_q <= bus.rd_in;
                            state_q  <= ST_DONE;
                        end else begin
                            state_q  <= ST_DIV;
                        end
                    end
                end
`ifndef MULDIV_FAST_MUL_EN
                ST_MUL: begin
                    prod_q <= prod_nxt;
                    cnt_q  <= cnt_q + 5'd1;
                    if (last_iter) begin
                        result_q <= mul_res;
                        rd_out_q <= rd_q;
                        state_q  <= ST_DONE;
                    end
                end
`endif
                ST_DIV: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (last_iter) begin
                        result_q <= div_res;
                        rd_out_q <= rd_q;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.stall  = accept || (((state_q == ST_MUL) || (state_q == ST_DIV)) && !bus.flush);
    assign bus.done   = (state_q == ST_DONE) && !bus.flush;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV32M cases plus random ops against an arithmetic model.
// Expected result, rd and completion cycle are queued at issue; a monitor checks every done pulse.
// Also covers stall length, flush mid-divide and asynchronous reset mid-operation.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t sb[$];

    ex_muldiv_unit_if bus();

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, want);
        end
    endtask

    // Arithmetic reference: RV32M semantics expressed with 64-bit and native integer operators
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sbv;
        logic [63:0] p;
        int          ia;
        int          ib;
        if (!f[2]) begin
            sa  = (f == 3'b011) ? longint'(a) : longint'($signed(a));
            sbv = (f == 3'b010 || f == 3'b011) ? longint'(b) : longint'($signed(b));
            p   = sa * sbv;
            return (f == 3'b000) ? p[31:0] : p[63:32];
        end
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
            ia = $signed(a);
            ib = $signed(b);
            return f[1] ? 32'(ia % ib) : 32'(ia / ib);
        end
        return f[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            return 1;
`else
            return 33;
`endif
        end
        if (b == 32'd0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Present one instruction in EX, hold it while stalled, check the stall length
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit now);
        int   lat;
        int   nst;
        exp_t e;
        lat = ref_lat(f, a, b);
        if (!now) begin
            @(posedge clk);
            #1;
        end
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        e.res = ref_res(f, a, b);
        e.rd  = rd;
        e.due = cyc + lat;
        sb.push_back(e);
        nst = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.stall) break;
            nst++;
        end
        chk($sformatf("stall_cycles f=%0d a=%h b=%h", f, a, b), 32'(nst), 32'(lat));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d want no pending op", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("result", bus.result, e.res);
                    chk("rd_out", 32'(bus.rd_out), 32'(e.rd));
                    chk("done_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          mode;

        rst        = 1'b1;
        bus.flush  = 1'b0;
        bus.start  = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.rd_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall",  32'(bus.stall),  32'd0);
        chk("reset_done",   32'(bus.done),   32'd0);
        chk("reset_result", bus.result,      32'd0);
        chk("reset_rd_out", 32'(bus.rd_out), 32'd0);
        rst = 1'b0;

        // Directed cases
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);
        issue(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 1'b0);
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 1'b0);
        issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1'b0);
        issue(3'b100, 32'hFFFF_FFEC, 32'd3, 5'd10, 1'b0);
        issue(3'b110, 32'hFFFF_FFEC, 32'd3, 5'd11, 1'b0);
        issue(3'b101, 32'd20, 32'd3, 5'd12, 1'b0);
        issue(3'b111, 32'd20, 32'd3, 5'd13, 1'b0);
        issue(3'b100, 32'd5, 32'd0, 5'd14, 1'b0);
        issue(3'b110, 32'd5, 32'd0, 5'd15, 1'b0);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b0);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1'b0);

        // Flush during divide iteration 10, then a new op in the very next cycle
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.funct3 = 3'b100;
        bus.op_a   = 32'd1000;
        bus.op_b   = 32'd7;
        bus.rd_in  = 5'd4;
        repeat (10) @(posedge clk);
        #1;
        chk("stall_before_flush", 32'(bus.stall), 32'd1);
        bus.flush = 1'b1;
        #1;
        chk("stall_during_flush", 32'(bus.stall), 32'd0);
        chk("done_during_flush",  32'(bus.done),  32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        issue(3'b101, 32'd9, 32'd2, 5'd6, 1'b1);

        // Random ops, biased toward divide corner cases and small operands
        for (int n = 0; n < 40; n++) begin
            f    = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 9);
            a    = $urandom;
            b    = $urandom;
            if (mode == 0) b = 32'd0;
            if (mode == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (mode == 2) begin
                a = $urandom_range(0, 50) - 25;
                b = $urandom_range(1, 9);
            end
            issue(f, a, b, 5'($urandom_range(0, 31)), 1'b0);
        end

        // Leave a known nonzero result, then reset in the middle of a long operation
        issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
        bus.funct3 = 3'b101;
`else
        bus.funct3 = 3'b000;
`endif
        bus.op_a  = 32'd1234;
        bus.op_b  = 32'd5678;
        bus.rd_in = 5'd9;
        repeat (5) @(posedge clk);
        #3;
        bus.start = 1'b0;
        rst       = 1'b1;
        #1;
        chk("midop_reset_stall",  32'(bus.stall),  32'd0);
        chk("midop_reset_done",   32'(bus.done),   32'd0);
        chk("midop_reset_result", bus.result,      32'd0);
        chk("midop_reset_rd_out", 32'(bus.rd_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(3'b101, 32'd100, 32'd7, 5'd9, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the EX-stage operands, rd and funct3 of an M-extension instruction, and runs a multi-cycle FSM. While it runs it raises a stall request to the hazard unit, then presents a one-cycle result for the EX/MEM register to capture. Operand selection and forwarding happen upstream in EX; this block only sees final operand values.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports (single clock `clk`; `rst` is asynchronous and active-high):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- flush  in  1  abort the current operation (branch/jump redirect)
- start  in  1  EX holds a valid M-extension instruction (MulDivE & ~bubble)
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  32  rs1 value (forwarded)
- op_b  in  32  rs2 value (forwarded)
- rd_in  in  5  destination register
- stall  out  1  stall request to hazard unit; freezes IF/ID/EX
- done  out  1  result valid this cycle
- result  out  32  registered result
- rd_out  out  5  rd of the completed op

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE: if start & ~flush, latch funct3, rd and operand magnitudes/signs. Then:
  - multiply: go to MUL.
  - divide by zero or signed overflow: go straight to DONE.
  - otherwise: go to DIV.
- MUL: shift-add, one bit per cycle, 32 cycles (5-bit counter), 64-bit product. Then DONE.
- DIV: restoring division on unsigned magnitudes, 32 cycles. Then DONE.
- DONE: done=1; result and rd_out are valid. `start` is ignored in this state because the same instruction is still in EX. Next state is IDLE.
- stall = (IDLE & start & ~flush) | MUL | DIV. It is low in DONE, so the pipeline advances on that edge.
- Result rules:
  - MUL takes the low 32 bits of the product; MULH/MULHSU/MULHU take the high 32 bits.
  - Signedness per operand: signed×signed, signed×unsigned, unsigned×unsigned respectively.
  - Sign correction is a 64-bit two's-complement negate when the operand signs differ.
  - Quotient is negated if the signs differ (DIV only). Remainder takes the sign of the dividend (REM only).
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = op_a.
  - Overflow (0x80000000 / 0xFFFFFFFF, signed): quotient = 0x80000000, remainder = 0.
- flush in any state: next state IDLE, done=0, stall drops combinationally in that cycle. result and rd_out keep their old values.
- Reset: state IDLE, counter 0, stall 0, done 0, result 0, rd_out 0, internal accumulators 0.

## Timing
- Accept edge: the rising edge at which IDLE & start & ~flush.
- Iterative multiply: stall is high for 33 cycles (accept cycle + 32 MUL cycles). done is high in cycle 34.
- Normal divide: same as iterative multiply, 33 stall cycles, done in cycle 34.
- Divide special case: stall is high for 1 cycle; done is high in cycle 2.
- result/rd_out are registered and stable throughout DONE; they hold until the next completion.
- Back-to-back ops: the earliest next accept is the cycle after DONE.
- Reset asserted mid-operation clears everything immediately (asynchronous).

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - multiply uses a single-cycle 33×33 signed combinational product, captured at the accept edge.
  - IDLE goes directly to DONE; stall is high 1 cycle and done is in cycle 2.
  - MUL state is unused.
- MULDIV_FAST_MUL_EN undefined: multiply is the 32-cycle iterative path described above.
- Divide behaviour is identical in both builds.

## Structure
- Shared package muldiv_pkg holds:
  - muldiv_op_e enum (funct3 encodings).
  - muldiv_state_e enum.
  - constants MULDIV_ITER=32, DIV0_QUOT=32'hFFFF_FFFF, OVF_QUOT=32'h8000_0000.
- One sub-module, div_core_iter: restoring divider datapath (remainder/quotient shift registers, one step per enable). The FSM, sign handling and multiply stay in ex_muldiv_unit.

## Test plan
- MUL 7 × −3 (op_a=7, op_b=0xFFFFFFFD), rd=5 -> stall high 33 cycles (1 with MULDIV_FAST_MUL_EN); done for 1 cycle with result=0xFFFFFFEB, rd_out=5.
- MULH/MULHSU/MULHU on 0x80000000 × 0xFFFFFFFF -> results 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
- DIV −20/3 -> 0xFFFFFFFA. REM −20/3 -> 0xFFFFFFFE. DIVU 20/3 -> 6. REMU 20/3 -> 2. Each has done in cycle 34.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0. Each has a 1-cycle stall and done in cycle 2.
- Flush at DIV iteration 10 -> stall drops that cycle, state IDLE next edge, no done. A new DIVU 9/2 accepted next cycle -> 4.
- rst pulse mid-MUL -> all outputs 0 immediately. start held through DONE -> exactly one done pulse.
